// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg : shared encodings for the hazard controller     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT       = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } hz_state_e;

    localparam logic [1:0] BR_PC4       = 2'b00;
    localparam logic [1:0] BR_PC_IMM    = 2'b01;
    localparam logic [1:0] BR_PC_IMMRS1 = 2'b10;
    localparam logic [1:0] BR_RSVD      = 2'b11;

    localparam logic [1:0] FD_RF  = 2'b00;
    localparam logic [1:0] FD_MEM = 2'b01;
    localparam logic [1:0] FD_WB  = 2'b10;

    function automatic logic is_redirect(input logic [1:0] br);
        return (br == BR_PC_IMM) || (br == BR_PC_IMMRS1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_sel : operand forwarding select for one EXE source register       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_we_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_we_i,
    output logic [1:0] sel_o
);

    logic mem_hit_w;
    logic wb_hit_w;

    assign mem_hit_w = mem_we_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs_addr_i);
    assign wb_hit_w  = wb_we_i  && (wb_rd_i  != 5'd0) && (wb_rd_i  == rs_addr_i);

    // MEM holds the younger result, so it wins over WB
    assign sel_o = mem_hit_w ? FD_MEM : (wb_hit_w ? FD_WB : FD_RF);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl : forwarding, load-use stall, redirect and memory    |
// | wait control for a 5-stage pipeline.  Revision 1.0                    |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             dec_rs1_addr,
    input  logic [4:0]             dec_rs2_addr,
    input  logic [4:0]             ID_rs1_addr,
    input  logic [4:0]             ID_rs2_addr,
    input  logic [4:0]             ID_rd_addr,
    input  logic                   ID_MemRead,
    input  logic                   ID_RegWrite,
    input  logic [4:0]             EXE_rd_addr,
    input  logic                   EXE_RegWrite,
    input  logic [4:0]             WB_rd_addr,
    input  logic                   WB_RegWrite,
    input  logic [1:0]             BranchCtrl,
    input  logic                   im_wait,
    input  logic                   dm_wait,
    output logic [1:0]             FDSignal1,
    output logic [1:0]             FDSignal2,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idexe_flush,
    output logic                   pipe_hold,
    output logic [1:0]             redirect_sel,
    output logic                   redirect_en,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    hz_state_e              state_q, state_d;
    logic [1:0]             pend_q, pend_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [1:0]             fd1_w, fd2_w;
    logic                   mem_wait_w;
    logic                   load_use_w;

    fwd_sel u_fwd_rs1 (
        .rs_addr_i (ID_rs1_addr),
        .mem_rd_i  (EXE_rd_addr),
        .mem_we_i  (EXE_RegWrite),
        .wb_rd_i   (WB_rd_addr),
        .wb_we_i   (WB_RegWrite),
        .sel_o     (fd1_w)
    );

    fwd_sel u_fwd_rs2 (
        .rs_addr_i (ID_rs2_addr),
        .mem_rd_i  (EXE_rd_addr),
        .mem_we_i  (EXE_RegWrite),
        .wb_rd_i   (WB_rd_addr),
        .wb_we_i   (WB_RegWrite),
        .sel_o     (fd2_w)
    );

    assign FDSignal1  = rst ? FD_RF : fd1_w;
    assign FDSignal2  = rst ? FD_RF : fd2_w;
    assign mem_wait_w = im_wait | dm_wait;
    assign load_use_w = ID_MemRead && (ID_rd_addr != 5'd0) &&
                        ((ID_rd_addr == dec_rs1_addr) || (ID_rd_addr == dec_rs2_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pend_q  <= BR_PC4;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (mem_wait_w) begin
                    if (is_redirect(BranchCtrl)) begin
                        pend_d  = BranchCtrl;
                        state_d = ST_FLUSH_PEND;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH_PEND: begin
                if (!mem_wait_w) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A WAIT cycle whose memory is ready resolves exactly like a RUN cycle
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idexe_flush  = 1'b0;
        pipe_hold    = 1'b0;
        redirect_sel = BR_PC4;
        redirect_en  = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (mem_wait_w) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (state_q == ST_FLUSH_PEND) begin
            redirect_en  = 1'b1;
            redirect_sel = pend_q;
            ifid_flush   = 1'b1;
            idexe_flush  = 1'b1;
        end else if (is_redirect(BranchCtrl)) begin
            redirect_en  = 1'b1;
            redirect_sel = BranchCtrl;
            ifid_flush   = 1'b1;
            idexe_flush  = 1'b1;
        end else if (load_use_w) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idexe_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!pc_write && (stall_q != '1)) begin
            stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed + random bench with reference model    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    dec_rs1_addr, dec_rs2_addr, ID_rs1_addr, ID_rs2_addr, ID_rd_addr;
    logic          ID_MemRead, ID_RegWrite;
    logic [4:0]    EXE_rd_addr, WB_rd_addr;
    logic          EXE_RegWrite, WB_RegWrite;
    logic [1:0]    BranchCtrl;
    logic          im_wait, dm_wait;
    logic [1:0]    FDSignal1, FDSignal2, redirect_sel;
    logic          pc_write, ifid_write, ifid_flush, idexe_flush, pipe_hold, redirect_en;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int pend  = 0;   // pending redirect target, 0 = none
    int cnt   = 0;   // cycles with pc_write low, saturating

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_rd_addr(ID_rd_addr), .ID_MemRead(ID_MemRead), .ID_RegWrite(ID_RegWrite),
        .EXE_rd_addr(EXE_rd_addr), .EXE_RegWrite(EXE_RegWrite),
        .WB_rd_addr(WB_rd_addr), .WB_RegWrite(WB_RegWrite),
        .BranchCtrl(BranchCtrl), .im_wait(im_wait), .dm_wait(dm_wait),
        .FDSignal1(FDSignal1), .FDSignal2(FDSignal2),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idexe_flush(idexe_flush), .pipe_hold(pipe_hold),
        .redirect_sel(redirect_sel), .redirect_en(redirect_en), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd(input int rs);
        if (EXE_RegWrite && EXE_rd_addr != 0 && int'(EXE_rd_addr) == rs) return 1;
        if (WB_RegWrite && WB_rd_addr != 0 && int'(WB_rd_addr) == rs) return 2;
        return 0;
    endfunction

    task automatic idle();
        dec_rs1_addr = 0; dec_rs2_addr = 0; ID_rs1_addr = 0; ID_rs2_addr = 0;
        ID_rd_addr = 0; ID_MemRead = 0; ID_RegWrite = 0;
        EXE_rd_addr = 0; EXE_RegWrite = 0; WB_rd_addr = 0; WB_RegWrite = 0;
        BranchCtrl = 0; im_wait = 0; dm_wait = 0;
    endtask

    // Check one full cycle against the model, then advance the model over the edge
    task automatic cycle(input string tag);
        bit mw, redir, lu;
        int e_pcw, e_ifw, e_iff, e_ief, e_hold, e_rsel, e_ren;
        @(negedge clk);
        mw    = im_wait || dm_wait;
        redir = (BranchCtrl == 2'd1) || (BranchCtrl == 2'd2);
        lu    = ID_MemRead && ID_rd_addr != 0 &&
                (ID_rd_addr == dec_rs1_addr || ID_rd_addr == dec_rs2_addr);
        e_pcw = 1; e_ifw = 1; e_iff = 0; e_ief = 0; e_hold = 0; e_rsel = 0; e_ren = 0;
        if (mw) begin
            e_pcw = 0; e_ifw = 0; e_hold = 1;
        end else if (pend != 0 || redir) begin
            e_ren = 1; e_iff = 1; e_ief = 1;
            e_rsel = (pend != 0) ? pend : int'(BranchCtrl);
        end else if (lu) begin
            e_pcw = 0; e_ifw = 0; e_ief = 1;
        end
        chk({tag, ".fd1"},   16'(FDSignal1),    16'(fwd(int'(ID_rs1_addr))));
        chk({tag, ".fd2"},   16'(FDSignal2),    16'(fwd(int'(ID_rs2_addr))));
        chk({tag, ".pcw"},   16'(pc_write),     16'(e_pcw));
        chk({tag, ".ifw"},   16'(ifid_write),   16'(e_ifw));
        chk({tag, ".iff"},   16'(ifid_flush),   16'(e_iff));
        chk({tag, ".ief"},   16'(idexe_flush),  16'(e_ief));
        chk({tag, ".hold"},  16'(pipe_hold),    16'(e_hold));
        chk({tag, ".ren"},   16'(redirect_en),  16'(e_ren));
        if (e_ren != 0) chk({tag, ".rsel"}, 16'(redirect_sel), 16'(e_rsel));
        chk({tag, ".cnt"},   16'(stall_cnt),    16'(cnt));
        if (mw) begin
            if (pend == 0 && redir) pend = int'(BranchCtrl);
        end else begin
            pend = 0;
        end
        if (e_pcw == 0 && cnt < MAXC) cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        chk("rst.pcw",  16'(pc_write),    16'd0);
        chk("rst.ifw",  16'(ifid_write),  16'd0);
        chk("rst.ren",  16'(redirect_en), 16'd0);
        chk("rst.hold", 16'(pipe_hold),   16'd0);
        chk("rst.cnt",  16'(stall_cnt),   16'd0);
        ID_rs1_addr = 5; EXE_rd_addr = 5; EXE_RegWrite = 1; #1;
        chk("rst.fd1",  16'(FDSignal1),   16'd0);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;

        // Forwarding priority and fallback to WB
        EXE_rd_addr = 5; EXE_RegWrite = 1; ID_rs1_addr = 5; WB_rd_addr = 5; WB_RegWrite = 1; #1;
        chk("fwd.mem", 16'(FDSignal1), 16'd1);
        cycle("fwd_mem");
        EXE_rd_addr = 0; #1;
        chk("fwd.wb", 16'(FDSignal1), 16'd2);
        cycle("fwd_wb");
        idle();

        // Load-use: one bubble, then normal
        ID_MemRead = 1; ID_RegWrite = 1; ID_rd_addr = 3; dec_rs2_addr = 3; #1;
        chk("lu.pcw", 16'(pc_write), 16'd0);
        cycle("lu");
        ID_MemRead = 0; ID_rd_addr = 0;
        cycle("lu_after");

        // Redirect beats load-use
        ID_MemRead = 1; ID_rd_addr = 3; dec_rs2_addr = 3; BranchCtrl = 2'b10; #1;
        chk("br_lu.rsel", 16'(redirect_sel), 16'd2);
        cycle("br_lu");
        idle();

        // Branch latched during a 3-cycle data wait
        dm_wait = 1; BranchCtrl = 2'b01;
        cycle("dw1");
        BranchCtrl = 2'b10;
        cycle("dw2");
        cycle("dw3");
        dm_wait = 0; BranchCtrl = 0; #1;
        chk("dw.rsel", 16'(redirect_sel), 16'd1);
        cycle("dw_redir");
        cycle("dw_after");

        // Reset while a redirect is pending
        dm_wait = 1; BranchCtrl = 2'b01;
        cycle("rp1");
        BranchCtrl = 0;
        cycle("rp2");
        #2 rst = 1'b1; #1;
        chk("rp.cnt", 16'(stall_cnt), 16'd0);
        chk("rp.pcw", 16'(pc_write), 16'd0);
        @(posedge clk); #1;
        rst = 1'b0; pend = 0; cnt = 0; dm_wait = 0;
        #1;
        chk("rp.ren", 16'(redirect_en), 16'd0);
        cycle("rp_after");

        // Saturation
        im_wait = 1;
        for (int i = 0; i < (1 << CW) + 5; i++) cycle("sat");
        im_wait = 0; #1;
        chk("sat.cnt", 16'(stall_cnt), 16'(MAXC));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            dec_rs1_addr = 5'($urandom_range(0, 3)); dec_rs2_addr = 5'($urandom_range(0, 3));
            ID_rs1_addr  = 5'($urandom_range(0, 3)); ID_rs2_addr  = 5'($urandom_range(0, 3));
            ID_rd_addr   = 5'($urandom_range(0, 3)); ID_MemRead   = 1'($urandom_range(0, 1));
            ID_RegWrite  = 1'($urandom_range(0, 1));
            EXE_rd_addr  = 5'($urandom_range(0, 3)); EXE_RegWrite = 1'($urandom_range(0, 1));
            WB_rd_addr   = 5'($urandom_range(0, 3)); WB_RegWrite  = 1'($urandom_range(0, 1));
            BranchCtrl   = 2'($urandom_range(0, 3));
            im_wait      = ($urandom_range(0, 5) == 0);
            dm_wait      = ($urandom_range(0, 3) == 0);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
